// File: rtl/vx_commit_serializer_pkg.sv
// Shared types and geometry for the commit serializer: commit packet layout,
// packet index width and the per-packet lane-mask helper.
package vx_commit_serializer_pkg;

  localparam int unsigned NUM_THREADS = 8;
  localparam int unsigned SIMD_WIDTH  = 4;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned UUID_WIDTH  = 44;
  localparam int unsigned NW_WIDTH    = 2;
  localparam int unsigned PC_BITS     = 32;
  localparam int unsigned NR_BITS     = 5;

  localparam int unsigned NUM_PKTS    = NUM_THREADS / SIMD_WIDTH;
  localparam int unsigned SIMD_IDX_W  = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]            uuid;
    logic [NW_WIDTH-1:0]              wid;
    logic [SIMD_IDX_W-1:0]            sid;
    logic [PC_BITS-1:0]               PC;
    logic [SIMD_WIDTH-1:0]            tmask;
    logic                             wb;
    logic [NR_BITS-1:0]               rd;
    logic [SIMD_WIDTH-1:0][XLEN-1:0]  data;
    logic                             sop;
    logic                             eop;
  } commit_t;

  // Lane mask of packet idx within a full-warp thread mask.
  function automatic logic [SIMD_WIDTH-1:0] pkt_mask(
    input logic [NUM_THREADS-1:0] tmask,
    input logic [SIMD_IDX_W-1:0]  idx
  );
    logic [NUM_THREADS-1:0] sh;
    sh = tmask >> (int'(idx) * SIMD_WIDTH);
    return sh[SIMD_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/vx_commit_serializer_if.sv
// Commit interface: valid/ready handshake carrying one commit_t packet.
interface VX_commit_if;
  import vx_commit_serializer_pkg::*;

  logic    valid;
  commit_t data;
  logic    ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_commit_serializer_pkt_sel.sv
// Packet selector: from a per-packet non-empty vector, finds the first,
// the next after idx_i, and the last non-empty packet (0 when none).
module VX_commit_pkt_sel
  import vx_commit_serializer_pkg::*;
#(
  parameter int unsigned NUM_PKTS = vx_commit_serializer_pkg::NUM_PKTS,
  parameter int unsigned IDX_W    = SIMD_IDX_W
) (
  input  logic [NUM_PKTS-1:0] nonempty_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [IDX_W-1:0]    first_o,
  output logic [IDX_W-1:0]    next_o,
  output logic [IDX_W-1:0]    last_o
);

  logic found_first;
  logic found_next;

  always_comb begin
    first_o     = '0;
    next_o      = idx_i;
    last_o      = '0;
    found_first = 1'b0;
    found_next  = 1'b0;
    for (int unsigned p = 0; p < NUM_PKTS; p++) begin
      if (nonempty_i[p]) begin
        if (!found_first) begin
          first_o     = IDX_W'(p);
          found_first = 1'b1;
        end
        if (!found_next && (IDX_W'(p) > idx_i)) begin
          next_o     = IDX_W'(p);
          found_next = 1'b1;
        end
        last_o = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/vx_commit_serializer.sv
// Commit serializer: splits one full-warp result into PKT_LANES-wide commit packets.
// Optional COMMIT_SKIP_EMPTY_EN suppresses packets whose lane mask slice is empty.
module vx_commit_serializer
  import vx_commit_serializer_pkg::*;
#(
  parameter              INSTANCE_ID = "",
  parameter int unsigned NUM_LANES   = NUM_THREADS,
  parameter int unsigned PKT_LANES   = SIMD_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [UUID_WIDTH-1:0]     uuid_in,
  input  logic [NW_WIDTH-1:0]       wid_in,
  input  logic [PC_BITS-1:0]        PC_in,
  input  logic [NUM_LANES-1:0]      tmask_in,
  input  logic                      wb_in,
  input  logic [NR_BITS-1:0]        rd_in,
  input  logic [NUM_LANES*XLEN-1:0] data_in,

  VX_commit_if.master               commit_if
);

  // commit_t is sized from the package, so the lane geometry must agree with it.
  if (NUM_LANES != NUM_THREADS || PKT_LANES != SIMD_WIDTH) begin : g_cfg_err
    $error("%s: lane geometry must match vx_commit_serializer_pkg", INSTANCE_ID);
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [SIMD_IDX_W-1:0] LAST_PKT = SIMD_IDX_W'(NUM_PKTS - 1);

  logic [0:0]            state_q,    state_d;
  logic [SIMD_IDX_W-1:0] pkt_idx_q,  pkt_idx_d;
  logic [SIMD_IDX_W-1:0] last_idx_q, last_idx_d;
  logic                  sop_q,      sop_d;

  logic [UUID_WIDTH-1:0]     uuid_q;
  logic [NW_WIDTH-1:0]       wid_q;
  logic [PC_BITS-1:0]        pc_q;
  logic [NUM_LANES-1:0]      tmask_q;
  logic                      wb_q;
  logic [NR_BITS-1:0]        rd_q;
  logic [NUM_LANES*XLEN-1:0] data_q;

  logic                  accept;
  logic                  fire;
  logic                  last_fire;
  logic [SIMD_IDX_W-1:0] first_idx;
  logic [SIMD_IDX_W-1:0] next_idx;
  logic [SIMD_IDX_W-1:0] last_idx;

  assign fire      = commit_if.valid && commit_if.ready;
  assign last_fire = (state_q == SEND) && fire && (pkt_idx_q == last_idx_q);
  assign ready_in  = (state_q == IDLE) || last_fire;
  assign accept    = valid_in && ready_in;

`ifdef COMMIT_SKIP_EMPTY_EN
  // One selector serves both uses: first/last need the incoming mask only on
  // accept, and next is only needed when no accept happens in the same cycle.
  logic [NUM_PKTS-1:0] nonempty;

  always_comb begin
    nonempty = '0;
    for (int unsigned p = 0; p < NUM_PKTS; p++) begin
      nonempty[p] = |pkt_mask(accept ? tmask_in : tmask_q, SIMD_IDX_W'(p));
    end
  end

  VX_commit_pkt_sel #(
    .NUM_PKTS (NUM_PKTS),
    .IDX_W    (SIMD_IDX_W)
  ) pkt_sel (
    .nonempty_i (nonempty),
    .idx_i      (pkt_idx_q),
    .first_o    (first_idx),
    .next_o     (next_idx),
    .last_o     (last_idx)
  );
`else
  assign first_idx = '0;
  assign next_idx  = pkt_idx_q + SIMD_IDX_W'(1);
  // An all-inactive warp still commits, as a single packet.
  assign last_idx  = (tmask_in == '0) ? '0 : LAST_PKT;
`endif

  always_comb begin
    state_d    = state_q;
    pkt_idx_d  = pkt_idx_q;
    last_idx_d = last_idx_q;
    sop_d      = sop_q;
    if (accept) begin
      state_d    = SEND;
      pkt_idx_d  = first_idx;
      last_idx_d = last_idx;
      sop_d      = 1'b1;
    end else if (last_fire) begin
      state_d = IDLE;
    end else if (fire) begin
      pkt_idx_d = next_idx;
      sop_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pkt_idx_q  <= '0;
      last_idx_q <= '0;
      sop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_idx_q  <= pkt_idx_d;
      last_idx_q <= last_idx_d;
      sop_q      <= sop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      uuid_q  <= uuid_in;
      wid_q   <= wid_in;
      pc_q    <= PC_in;
      tmask_q <= tmask_in;
      wb_q    <= wb_in;
      rd_q    <= rd_in;
      data_q  <= data_in;
    end
  end

  logic [NUM_LANES*XLEN-1:0] data_sh;
  commit_t                   pkt;

  assign data_sh = data_q >> (int'(pkt_idx_q) * PKT_LANES * XLEN);

  always_comb begin
    pkt       = '0;
    pkt.uuid  = uuid_q;
    pkt.wid   = wid_q;
    pkt.sid   = pkt_idx_q;
    pkt.PC    = pc_q;
    pkt.tmask = pkt_mask(tmask_q, pkt_idx_q);
    pkt.wb    = wb_q;
    pkt.rd    = rd_q;
    pkt.data  = data_sh[PKT_LANES*XLEN-1:0];
    pkt.sop   = sop_q;
    pkt.eop   = (pkt_idx_q == last_idx_q);
  end

  assign commit_if.valid = (state_q == SEND);
  assign commit_if.data  = pkt;

endmodule

// File: tb/tb_vx_commit_serializer.sv
// Directed bench for vx_commit_serializer (8 lanes, 4-lane packets);
// expectations for the empty-packet cases follow COMMIT_SKIP_EMPTY_EN.
module tb_vx_commit_serializer;
  import vx_commit_serializer_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      valid_in;
  logic                      ready_in;
  logic [UUID_WIDTH-1:0]     uuid_in;
  logic [NW_WIDTH-1:0]       wid_in;
  logic [PC_BITS-1:0]        PC_in;
  logic [NUM_THREADS-1:0]    tmask_in;
  logic                      wb_in;
  logic [NR_BITS-1:0]        rd_in;
  logic [NUM_THREADS*XLEN-1:0] data_in;

  int n_checks = 0;
  int n_fail   = 0;

  VX_commit_if cif ();

  vx_commit_serializer #(.INSTANCE_ID("tb_dut")) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .uuid_in   (uuid_in),
    .wid_in    (wid_in),
    .PC_in     (PC_in),
    .tmask_in  (tmask_in),
    .wb_in     (wb_in),
    .rd_in     (rd_in),
    .data_in   (data_in),
    .commit_if (cif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_data(input logic [31:0] base, input int p);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = base + 32'(4 * p + j);
    return r;
  endfunction

  task automatic drive(input logic [43:0] uuid, input logic [1:0] wid,
                       input logic [7:0] tm, input logic [31:0] base);
    valid_in = 1'b1;
    uuid_in  = uuid;
    wid_in   = wid;
    PC_in    = base << 4;
    tmask_in = tm;
    wb_in    = base[0];
    rd_in    = base[4:0];
    for (int i = 0; i < 8; i++) data_in[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic chk_pkt(input string tag, input int sid, input logic sop, input logic eop,
                         input logic [3:0] tm, input logic [43:0] uuid, input logic [1:0] wid,
                         input logic [31:0] base);
    chk({tag, ".valid"}, 128'(cif.valid), 128'(1'b1));
    chk({tag, ".sid"},   128'(cif.data.sid), 128'(sid));
    chk({tag, ".sop"},   128'(cif.data.sop), 128'(sop));
    chk({tag, ".eop"},   128'(cif.data.eop), 128'(eop));
    chk({tag, ".tmask"}, 128'(cif.data.tmask), 128'(tm));
    chk({tag, ".uuid"},  128'(cif.data.uuid), 128'(uuid));
    chk({tag, ".wid"},   128'(cif.data.wid), 128'(wid));
    chk({tag, ".PC"},    128'(cif.data.PC), 128'(base << 4));
    chk({tag, ".rd"},    128'(cif.data.rd), 128'(base[4:0]));
    chk({tag, ".wb"},    128'(cif.data.wb), 128'(base[0]));
    chk({tag, ".data"},  128'(cif.data.data), exp_data(base, sid));
  endtask

  commit_t held;

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    cif.ready = 1'b1;
    uuid_in   = '0;
    wid_in    = '0;
    PC_in     = '0;
    tmask_in  = '0;
    wb_in     = 1'b0;
    rd_in     = '0;
    data_in   = '0;
    #1;
    chk("rst.valid", 128'(cif.valid), 128'(1'b0));
    chk("rst.ready_in", 128'(ready_in), 128'(1'b1));
    tick();
    tick();
    reset = 1'b0;
    chk("idle.valid", 128'(cif.valid), 128'(1'b0));

    // 1: full mask, two packets back to back
    drive(44'd1, 2'd1, 8'hFF, 32'h100);
    chk("t1.ready_in_idle", 128'(ready_in), 128'(1'b1));
    tick();
    valid_in = 1'b0;
    chk_pkt("t1.p0", 0, 1'b1, 1'b0, 4'hF, 44'd1, 2'd1, 32'h100);
    chk("t1.p0.ready_in", 128'(ready_in), 128'(1'b0));
    tick();
    chk_pkt("t1.p1", 1, 1'b0, 1'b1, 4'hF, 44'd1, 2'd1, 32'h100);
    chk("t1.p1.ready_in", 128'(ready_in), 128'(1'b1));
    tick();
    chk("t1.done.valid", 128'(cif.valid), 128'(1'b0));

    // 2: two instructions with no bubble between them
    drive(44'd2, 2'd2, 8'hFF, 32'h200);
    tick();
    drive(44'd3, 2'd3, 8'hFF, 32'h300);
    chk_pkt("t2.a0", 0, 1'b1, 1'b0, 4'hF, 44'd2, 2'd2, 32'h200);
    chk("t2.a0.ready_in", 128'(ready_in), 128'(1'b0));
    tick();
    chk_pkt("t2.a1", 1, 1'b0, 1'b1, 4'hF, 44'd2, 2'd2, 32'h200);
    chk("t2.a1.ready_in", 128'(ready_in), 128'(1'b1));
    tick();
    valid_in = 1'b0;
    chk_pkt("t2.b0", 0, 1'b1, 1'b0, 4'hF, 44'd3, 2'd3, 32'h300);
    tick();
    chk_pkt("t2.b1", 1, 1'b0, 1'b1, 4'hF, 44'd3, 2'd3, 32'h300);
    tick();
    chk("t2.done.valid", 128'(cif.valid), 128'(1'b0));

    // 3: downstream stall holds the first packet
    drive(44'd4, 2'd0, 8'h5A, 32'h400);
    cif.ready = 1'b0;
    tick();
    valid_in = 1'b0;
    chk_pkt("t3.p0", 0, 1'b1, 1'b0, 4'hA, 44'd4, 2'd0, 32'h400);
    held = cif.data;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3.hold.valid", 128'(cif.valid), 128'(1'b1));
      chk("t3.hold.data", 128'(cif.data != held), 128'(1'b0));
      chk("t3.hold.ready_in", 128'(ready_in), 128'(1'b0));
    end
    cif.ready = 1'b1;
    tick();
    chk_pkt("t3.p1", 1, 1'b0, 1'b1, 4'h5, 44'd4, 2'd0, 32'h400);
    tick();
    chk("t3.done.valid", 128'(cif.valid), 128'(1'b0));

    // 4: low packet empty
    drive(44'd5, 2'd1, 8'hF0, 32'h500);
    tick();
    valid_in = 1'b0;
`ifdef COMMIT_SKIP_EMPTY_EN
    chk_pkt("t4.p1", 1, 1'b1, 1'b1, 4'hF, 44'd5, 2'd1, 32'h500);
`else
    chk_pkt("t4.p0", 0, 1'b1, 1'b0, 4'h0, 44'd5, 2'd1, 32'h500);
    tick();
    chk_pkt("t4.p1", 1, 1'b0, 1'b1, 4'hF, 44'd5, 2'd1, 32'h500);
`endif
    tick();
    chk("t4.done.valid", 128'(cif.valid), 128'(1'b0));

    // 4b: high packet empty
    drive(44'd6, 2'd2, 8'h0F, 32'h600);
    tick();
    valid_in = 1'b0;
`ifdef COMMIT_SKIP_EMPTY_EN
    chk_pkt("t4b.p0", 0, 1'b1, 1'b1, 4'hF, 44'd6, 2'd2, 32'h600);
`else
    chk_pkt("t4b.p0", 0, 1'b1, 1'b0, 4'hF, 44'd6, 2'd2, 32'h600);
    tick();
    chk_pkt("t4b.p1", 1, 1'b0, 1'b1, 4'h0, 44'd6, 2'd2, 32'h600);
`endif
    tick();
    chk("t4b.done.valid", 128'(cif.valid), 128'(1'b0));

    // 5: fully inactive warp still commits once
    drive(44'd7, 2'd3, 8'h00, 32'h700);
    tick();
    valid_in = 1'b0;
    chk_pkt("t5.p0", 0, 1'b1, 1'b1, 4'h0, 44'd7, 2'd3, 32'h700);
    chk("t5.ready_in", 128'(ready_in), 128'(1'b1));
    tick();
    chk("t5.done.valid", 128'(cif.valid), 128'(1'b0));

    // 6: async reset while stalled on the first packet
    drive(44'd8, 2'd0, 8'hFF, 32'h800);
    cif.ready = 1'b0;
    tick();
    valid_in = 1'b0;
    chk_pkt("t6.p0", 0, 1'b1, 1'b0, 4'hF, 44'd8, 2'd0, 32'h800);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t6.rst.valid", 128'(cif.valid), 128'(1'b0));
    chk("t6.rst.ready_in", 128'(ready_in), 128'(1'b1));
    tick();
    reset     = 1'b0;
    cif.ready = 1'b1;
    chk("t6.rel.valid", 128'(cif.valid), 128'(1'b0));
    chk("t6.rel.ready_in", 128'(ready_in), 128'(1'b1));
    tick();
    chk("t6.no_sid1.a", 128'(cif.valid), 128'(1'b0));
    tick();
    chk("t6.no_sid1.b", 128'(cif.valid), 128'(1'b0));

    drive(44'd9, 2'd1, 8'h3C, 32'h900);
    tick();
    valid_in = 1'b0;
    chk_pkt("t6.new.p0", 0, 1'b1, 1'b0, 4'hC, 44'd9, 2'd1, 32'h900);
    tick();
    chk_pkt("t6.new.p1", 1, 1'b0, 1'b1, 4'h3, 44'd9, 2'd1, 32'h900);
    tick();
    chk("t6.done.valid", 128'(cif.valid), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
